// File: rtl/fp_mul_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_add_pkg
// Description : Shared types, constants and binary32 arithmetic helpers for
//               the sequenced multiply-add unit. The arithmetic flushes
//               subnormals to signed zero and rounds to nearest-even.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_add_pkg;

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_MUL  = 2'd1;
    localparam state_t c_ST_ADD  = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

    localparam logic [31:0] c_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] c_POS_INF = 32'h7F80_0000;

    localparam int c_DEF_MUL_LATENCY = 5;
    localparam int c_DEF_ADD_LATENCY = 7;

    // Rounded binary32 product, subnormals treated as zero
    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic               sa, sb, s;
        logic [7:0]         ea, eb;
        logic [22:0]        fa, fb;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0]        p;
        logic [23:0]        m;
        logic [24:0]        mr;
        logic               g, st;
        logic signed [9:0]  e;
        logic [31:0]        r;

        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        a_nan  = (ea == 8'hFF) && (fa != '0);
        b_nan  = (eb == 8'hFF) && (fb != '0);
        a_inf  = (ea == 8'hFF) && (fa == '0);
        b_inf  = (eb == 8'hFF) && (fb == '0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        s      = sa ^ sb;

        p = {1'b1, fa} * {1'b1, fb};
        // The product of two [1,2) significands lies in [1,4): pick the
        // leading-one position and fold the rest into guard/sticky.
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
            e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        end

        mr = {1'b0, m} + {24'd0, (g & (st | m[0]))};
        if (mr[24]) begin
            m = mr[24:1];
            e = e + 10'sd1;
        end else begin
            m = mr[23:0];
        end

        if (a_nan || b_nan)
            r = c_QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            r = c_QNAN;
        else if (a_inf || b_inf)
            r = {s, c_POS_INF[30:0]};
        else if (a_zero || b_zero)
            r = {s, 31'd0};
        else if (e >= 10'sd255)
            r = {s, c_POS_INF[30:0]};
        else if (e <= 10'sd0)
            r = {s, 31'd0};
        else
            r = {s, e[7:0], m[22:0]};
        return r;
    endfunction

    // Rounded binary32 sum, subnormals treated as zero
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic               sa, sb, sbig, ssml;
        logic [7:0]         ea, eb, ebig, esml, diff;
        logic [22:0]        fa, fb;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [23:0]        mbig, msml, m;
        logic [24:0]        mr;
        logic [5:0]         sh, pos;
        logic [50:0]        xb, xs;
        logic [51:0]        sm, norm;
        logic               g, st;
        logic signed [9:0]  e;
        logic [31:0]        r;

        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        a_nan  = (ea == 8'hFF) && (fa != '0);
        b_nan  = (eb == 8'hFF) && (fb != '0);
        a_inf  = (ea == 8'hFF) && (fa == '0);
        b_inf  = (eb == 8'hFF) && (fb == '0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);

        // Order by magnitude so the subtraction never goes negative
        if ({ea, fa} >= {eb, fb}) begin
            sbig = sa; ebig = ea; mbig = {1'b1, fa};
            ssml = sb; esml = eb; msml = {1'b1, fb};
        end else begin
            sbig = sb; ebig = eb; mbig = {1'b1, fb};
            ssml = sa; esml = ea; msml = {1'b1, fa};
        end
        diff = ebig - esml;
        // Beyond 27 places the small operand only matters as sticky; a
        // clamped shift keeps it as a non-zero tail well below the guard.
        sh   = (diff > 8'd27) ? 6'd27 : diff[5:0];
        xb   = {mbig, 27'd0};
        xs   = {msml, 27'd0} >> sh;

        if (sbig == ssml)
            sm = {1'b0, xb} + {1'b0, xs};
        else
            sm = {1'b0, xb} - {1'b0, xs};

        pos = 6'd0;
        for (int i = 0; i < 52; i++) begin
            if (sm[i])
                pos = 6'(i);
        end
        norm = sm << (6'd51 - pos);
        m    = norm[51:28];
        g    = norm[27];
        st   = |norm[26:0];
        // Bit 50 of the aligned sum carries the larger operand's exponent
        e    = $signed({2'b00, ebig}) + $signed({4'b0000, pos}) - 10'sd50;

        mr = {1'b0, m} + {24'd0, (g & (st | m[0]))};
        if (mr[24]) begin
            m = mr[24:1];
            e = e + 10'sd1;
        end else begin
            m = mr[23:0];
        end

        if (a_nan || b_nan)
            r = c_QNAN;
        else if (a_inf && b_inf && (sa != sb))
            r = c_QNAN;
        else if (a_inf)
            r = {sa, c_POS_INF[30:0]};
        else if (b_inf)
            r = {sb, c_POS_INF[30:0]};
        else if (a_zero && b_zero)
            r = {sa & sb, 31'd0};
        else if (a_zero)
            r = b;
        else if (b_zero)
            r = a;
        else if (sm == '0)
            r = 32'h0000_0000;
        else if (e >= 10'sd255)
            r = {sbig, c_POS_INF[30:0]};
        else if (e <= 10'sd0)
            r = {sbig, 31'd0};
        else
            r = {sbig, e[7:0], m[22:0]};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_counter.sv
`default_nettype none
// ============================================================================
// Module      : delay_counter
// Description : Loadable down-counter. A load with value N raises expired
//               for exactly one cycle, so the consumer sees it at the edge
//               N cycles after the load edge. Loading zero idles the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_counter #(
    parameter int COUNTER_WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [COUNTER_WIDTH-1:0] max,
    output logic                     expired
);

    logic [COUNTER_WIDTH-1:0] r_count;

    // Load on rst, otherwise count down to zero and stop there
    always_ff @(posedge clock) begin
        if (rst)
            r_count <= max;
        else if (r_count != '0)
            r_count <= r_count - COUNTER_WIDTH'(1);
    end

    assign expired = (r_count == COUNTER_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/fp_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_add
// Description : Sequenced binary32 multiply-add, result = a*b + b, with
//               separately rounded product and sum, fixed stage latencies
//               and a one-cycle done pulse on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_add
    import fp_mul_add_pkg::*;
#(
    parameter int MUL_LATENCY   = c_DEF_MUL_LATENCY,
    parameter int ADD_LATENCY   = c_DEF_ADD_LATENCY,
    parameter int COUNTER_WIDTH = 10,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] dataa,
    input  logic [DATA_WIDTH-1:0] datab,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done
);

    state_t                   r_state;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [DATA_WIDTH-1:0]    r_prod;
    logic [DATA_WIDTH-1:0]    r_result;
    logic                     r_done;

    logic                     w_start;
    logic                     w_load;
    logic                     w_expired;
    logic [COUNTER_WIDTH-1:0] w_max;
    logic [DATA_WIDTH-1:0]    w_prod;
    logic [DATA_WIDTH-1:0]    w_sum;

    // Counter reloads: stage entries, plus a zero load on reset to clear it
    always_comb begin
        w_start = (r_state == c_ST_IDLE) && clk_en;
        w_load  = aclr || w_start || ((r_state == c_ST_MUL) && w_expired);
        if (aclr)
            w_max = '0;
        else if (r_state == c_ST_IDLE)
            w_max = COUNTER_WIDTH'(MUL_LATENCY);
        else
            w_max = COUNTER_WIDTH'(ADD_LATENCY);
    end

    assign w_prod = fp32_mul(r_a, r_b);
    assign w_sum  = fp32_add(r_prod, r_b);

    delay_counter #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_delay_counter (
        .clock   (clock),
        .rst     (w_load),
        .max     (w_max),
        .expired (w_expired)
    );

    // Sequencer: capture operands, hold each stage for its latency, publish
    always_ff @(posedge clock) begin
        if (aclr) begin
            r_state  <= c_ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (clk_en) begin
                        r_a     <= dataa;
                        r_b     <= datab;
                        r_state <= c_ST_MUL;
                    end
                end
                c_ST_MUL: begin
                    r_prod <= w_prod;
                    if (w_expired)
                        r_state <= c_ST_ADD;
                end
                c_ST_ADD: begin
                    if (w_expired) begin
                        r_result <= w_sum;
                        r_done   <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_add
// Description : Directed self-checking bench for fp_mul_add.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_add;

    logic        clock = 1'b0;
    logic        aclr  = 1'b1;
    logic        clk_en = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;

    int checks = 0;
    int errors = 0;

    localparam int c_LAT = 12;

    fp_mul_add #(
        .MUL_LATENCY   (5),
        .ADD_LATENCY   (7),
        .COUNTER_WIDTH (10),
        .DATA_WIDTH    (32)
    ) dut (
        .clock  (clock),
        .aclr   (aclr),
        .clk_en (clk_en),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clock = ~clock;

    // One idle edge, a one-cycle request, then count edges until done
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                         input bit wiggle, output int lat, output logic [31:0] res);
        @(posedge clock); #1;
        dataa  = a;
        datab  = b;
        clk_en = 1'b1;
        @(posedge clock); #1;
        clk_en = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (scramble && lat == 1) begin
                dataa = 32'hDEAD_BEEF;
                datab = 32'h1234_5678;
            end
            if (wiggle)
                clk_en = ~clk_en;
            if (done)
                break;
        end
        clk_en = 1'b0;
        res = result;
    endtask

    task automatic test_reset();
        int seen;
        aclr = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (result !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h expected %h", result, 32'h0);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected %b", done, 1'b0);
        end
        aclr = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL idle_no_done: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] res;
        do_op(32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, lat, res);
        checks++;
        if (lat != c_LAT) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, c_LAT);
        end
        checks++;
        if (res !== 32'h4110_0000) begin
            errors++; $display("FAIL basic_2x3p3: got %h expected %h", res, 32'h4110_0000);
        end
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: got %b expected %b", done, 1'b0);
        end
        checks++;
        if (result !== 32'h4110_0000) begin
            errors++; $display("FAIL result_held: got %h expected %h", result, 32'h4110_0000);
        end
    endtask

    task automatic test_capture();
        int lat;
        logic [31:0] res;
        do_op(32'h3FC0_0000, 32'hC000_0000, 1'b1, 1'b0, lat, res);
        checks++;
        if (res !== 32'hC0A0_0000 || lat != c_LAT) begin
            errors++; $display("FAIL capture_neg5: got %h lat %0d expected %h lat %0d", res, lat, 32'hC0A0_0000, c_LAT);
        end
    endtask

    task automatic test_special();
        int lat;
        logic [31:0] res;
        do_op(32'h0000_0000, 32'h40A0_0000, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h40A0_0000) begin
            errors++; $display("FAIL zero_times_5: got %h expected %h", res, 32'h40A0_0000);
        end
        do_op(32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h7FC0_0000) begin
            errors++; $display("FAIL inf_times_zero: got %h expected %h", res, 32'h7FC0_0000);
        end
        do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h7F80_0000) begin
            errors++; $display("FAIL overflow: got %h expected %h", res, 32'h7F80_0000);
        end
        do_op(32'hBF80_0000, 32'h4000_0000, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h0000_0000) begin
            errors++; $display("FAIL exact_cancel: got %h expected %h", res, 32'h0000_0000);
        end
        do_op(32'hBF40_0000, 32'h4080_0000, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h3F80_0000) begin
            errors++; $display("FAIL subtract: got %h expected %h", res, 32'h3F80_0000);
        end
    endtask

    task automatic test_rounding();
        int lat;
        logic [31:0] res;
        // (1+2^-23)^2 rounds to 1+2^-22; adding 1+2^-23 is a tie resolved to even
        do_op(32'h3F80_0001, 32'h3F80_0001, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h4000_0002) begin
            errors++; $display("FAIL rne_tie: got %h expected %h", res, 32'h4000_0002);
        end
        do_op(32'h4000_0000, 32'h0000_0001, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h0000_0000) begin
            errors++; $display("FAIL subnormal_flush: got %h expected %h", res, 32'h0000_0000);
        end
        do_op(32'h4000_0000, 32'h8000_0001, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 32'h8000_0000) begin
            errors++; $display("FAIL neg_zero_sum: got %h expected %h", res, 32'h8000_0000);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int lat;
        int seen;
        logic [31:0] res;
        @(posedge clock); #1;
        dataa  = 32'h4000_0000;
        datab  = 32'h4040_0000;
        clk_en = 1'b1;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clock); #1;
            if (done) begin
                checks++;
                if (k != c_LAT + 14 * pulses || result !== 32'h4110_0000) begin
                    errors++; $display("FAIL b2b_pulse: got edge %0d value %h expected edge %0d value %h",
                                       k, result, c_LAT + 14 * pulses, 32'h4110_0000);
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++; $display("FAIL b2b_count: got %0d expected 3", pulses);
        end
        clk_en = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(posedge clock); #1;
            if (done) seen = 1;
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("FAIL b2b_drain: got %0d expected 1", seen);
        end
        // Request toggling during MUL/ADD, then held high through DONE
        do_op(32'h3FC0_0000, 32'hC000_0000, 1'b0, 1'b1, lat, res);
        checks++;
        if (lat != c_LAT || res !== 32'hC0A0_0000) begin
            errors++; $display("FAIL wiggle_op: got lat %0d value %h expected lat %0d value %h", lat, res, c_LAT, 32'hC0A0_0000);
        end
        clk_en = 1'b1;
        @(posedge clock); #1;
        clk_en = 1'b0;
        seen = 0;
        repeat (16) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL done_state_ignores_req: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        logic [31:0] res;
        @(posedge clock); #1;
        dataa  = 32'h40A0_0000;
        datab  = 32'h3F80_0000;
        clk_en = 1'b1;
        @(posedge clock); #1;
        clk_en = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        aclr = 1'b1;
        @(posedge clock); #1;
        aclr = 1'b0;
        checks++;
        if (result !== 32'h0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_state: got %h/%b expected %h/%b", result, done, 32'h0, 1'b0);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen);
        end
        do_op(32'h40A0_0000, 32'h3F80_0000, 1'b0, 1'b0, lat, res);
        checks++;
        if (lat != c_LAT || res !== 32'h40C0_0000) begin
            errors++; $display("FAIL after_abort: got lat %0d value %h expected lat %0d value %h", lat, res, c_LAT, 32'h40C0_0000);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_capture();
        test_special();
        test_rounding();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_add.md
# fp_mul_add

Sequenced single-precision floating-point multiply-add unit: on a start request it computes result = (dataa × datab) + datab in IEEE-754 binary32. The multiply and add stages take fixed, parameterised latencies, timed by an internal delay counter, and completion is signalled by a one-cycle done pulse. It serves as the arithmetic step engine for the CORDIC datapath, which issues one operation at a time and waits for done.

## Interface
Parameters:
- MUL_LATENCY, 5, cycles spent in the multiply stage (≥1)
- ADD_LATENCY, 7, cycles spent in the add stage (≥1)
- COUNTER_WIDTH, 10, width of the delay counter (must hold max latency)
- DATA_WIDTH, 32, operand/result width (fixed at 32, binary32)

Ports:
- clock  in  1  single clock, all state changes on rising edge
- aclr  in  1  reset, synchronous and active-high
- clk_en  in  1  start request, sampled only in IDLE
- dataa  in  32  multiplicand (binary32)
- datab  in  32  multiplier and addend (binary32)
- result  out  32  registered result, held until the next completion
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, MUL, ADD, DONE.
- IDLE: clk_en=1 at an edge → capture dataa/datab into operand registers, load counter with MUL_LATENCY, go to MUL. Otherwise stay.
- MUL: counter runs; product register = fp_mul(a,b). When the counter expires → load ADD_LATENCY, go to ADD.
- ADD: sum = fp_add(product, b). When the counter expires → result ← sum, done ← 1, go to DONE.
- DONE: done ← 0, go to IDLE.
- clk_en outside IDLE is ignored. Input changes after capture do not affect the operation.
- Arithmetic is not fused: the product is rounded, then the sum is rounded. Rounding is round-to-nearest-even.
- Subnormal inputs and outputs are flushed to signed zero.
- Overflow → signed infinity.
- Any NaN input, inf×0, or (+inf)+(−inf) → canonical qNaN 0x7FC00000.
- Exact zero sum of opposite-sign operands → +0.
- Zero sign rules:
  - product sign = XOR of the operand signs
  - (−0)+(−0) = −0

## Timing
- E0 = edge sampling clk_en=1 in IDLE.
- State transitions:
  - MUL entered at E0
  - ADD entered at E0+MUL_LATENCY
  - DONE entered at E0+MUL_LATENCY+ADD_LATENCY (E12 with defaults); result and done update at this edge
- done is high for exactly one cycle and drops at E13. The next request can be accepted at E14 at the earliest.
- aclr=1 at an edge:
  - state ← IDLE, result ← 0x00000000, done ← 0, counter cleared
  - an in-flight operation is aborted and produces no done
- aclr has priority over clk_en.
- Power-up values equal the reset values.

## Structure
- Package fp_mul_add_pkg contains:
  - state enum
  - constants: QNAN=0x7FC00000, POS_INF=0x7F800000
  - default latencies
  - pure combinational functions fp32_mul and fp32_add (unpack, align/normalise, RNE, special-case handling)
- Sub-module delay_counter:
  - inputs: clock, rst (load pulse), max [COUNTER_WIDTH]
  - output: expired
  - on load, counts to max and asserts expired for exactly one cycle, max cycles after the load edge
- The FSM sequences the loads and uses expired to advance.

## Test plan
- 0x40000000 (2.0), 0x40400000 (3.0) → result 0x41100000 (9.0); done pulses one cycle, exactly 12 edges after E0.
- 0x3FC00000 (1.5), 0xC0000000 (−2.0) → 0xC0A00000 (−5.0). Inputs changed to garbage at E1 → result unchanged.
- 0x00000000, 0x40A00000 → 0x40A00000. Then dataa=0x7F800000, datab=0 → 0x7FC00000. Then 0x7F7FFFFF, 0x7F7FFFFF → 0x7F800000.
- clk_en held high continuously → done every 14 cycles; clk_en pulses during MUL/ADD/DONE are ignored.
- aclr asserted at E0+6 → result 0, done stays 0, state IDLE. A new request afterwards completes normally.
- Rounding and subnormal handling:
  - 0x3F800001 × 0x3F800001 + 0x3F800001 checks RNE against a non-fused reference model
  - subnormal input 0x00000001 is treated as 0
